// File: rtl/crc_serial_gen_if.sv
// -----------------------------------------------------------------------------
// crc_serial_gen_if
//
// Groups the serial frame input and the serial CRC output of crc_serial_gen.
//
// Handshake (one rule for the whole block):
//   A DATA bit is transferred on a rising CLK edge when ACTIVE && READY.
//   ACTIVE high means "this cycle carries a frame bit". The first sampled
//   ACTIVE low ends the frame. While READY is low the engine is shifting its
//   CRC out, and any DATA/ACTIVE presented then is dropped. The source must
//   wait for READY before it starts or continues a frame.
//   On the output side, CRC is meaningful only while VALID is high. DONE
//   pulses for one cycle after the last CRC bit.
//
// Signals:
//   DATA    source -> engine  serial data bit
//   ACTIVE  source -> engine  DATA qualifier / frame envelope
//   READY   engine -> source  DATA/ACTIVE accepted this cycle
//   CRC     engine -> sink    serial CRC bit (LSB of the final LFSR first)
//   VALID   engine -> sink    CRC bit valid
//   DONE    engine -> sink    one-cycle pulse after the last CRC bit
//   OVF     engine -> sink    sticky frame-too-long flag
//   CHK_OK  engine -> sink    residue-zero flag (only with CRC_SERIAL_CHECK_EN)
//
// Modports: master = frame source / CRC sink side, slave = the CRC engine.
// Build option: CRC_SERIAL_CHECK_EN adds CHK_OK.
// -----------------------------------------------------------------------------
interface crc_serial_gen_if;
  logic DATA;
  logic ACTIVE;
  logic READY;
  logic CRC;
  logic VALID;
  logic DONE;
  logic OVF;
`ifdef CRC_SERIAL_CHECK_EN
  logic CHK_OK;

  modport master (
    output DATA,
    output ACTIVE,
    input  READY,
    input  CRC,
    input  VALID,
    input  DONE,
    input  OVF,
    input  CHK_OK
  );

  modport slave (
    input  DATA,
    input  ACTIVE,
    output READY,
    output CRC,
    output VALID,
    output DONE,
    output OVF,
    output CHK_OK
  );
`else
  modport master (
    output DATA,
    output ACTIVE,
    input  READY,
    input  CRC,
    input  VALID,
    input  DONE,
    input  OVF
  );

  modport slave (
    input  DATA,
    input  ACTIVE,
    output READY,
    output CRC,
    output VALID,
    output DONE,
    output OVF
  );
`endif
endinterface

// File: rtl/crc_serial_gen.sv
// -----------------------------------------------------------------------------
// crc_serial_gen
//
// Bit-serial LFSR CRC engine. It absorbs a variable-length frame one bit per
// cycle. When the frame ends it shifts the CRC out LSB first, with a per-bit
// VALID and a DONE pulse. It then reloads SEED for the next frame. A frame
// longer than MAX_BITS is cut at MAX_BITS bits and flagged on OVF.
//
// Parameters:
//   CRC_W     LFSR / CRC width (2..32)
//   TAPS      tap mask; bit j set -> LFSR[j] gets LFSR[j+1] ^ feedback
//   SEED      LFSR value at reset and at the start of every frame
//   MAX_BITS  maximum data bits absorbed per frame (1..65535)
//   CNT_W     data-bit counter width, >= clog2(MAX_BITS+1)
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous, active-low reset
//   bus        crc_serial_gen_if.slave (DATA, ACTIVE, READY, CRC, VALID,
//              DONE, OVF, and CHK_OK when enabled)
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 SHIFT)
//   dbg_lfsr   current LFSR contents
//
// Build option: define CRC_SERIAL_CHECK_EN to add CHK_OK. CHK_OK is set when
// the LFSR is zero after absorbing a frame, which is the receive-side check
// when the frame carries its own CRC. When the macro is undefined, the
// CHK_OK port and its logic are absent.
//
// Every output comes from a flop. READY is registered from the next state, so
// the path from the inputs to the outputs always passes through a register.
// -----------------------------------------------------------------------------
module crc_serial_gen #(
  parameter int              CRC_W    = 8,
  parameter logic [CRC_W-1:0] TAPS    = 8'h44,
  parameter logic [CRC_W-1:0] SEED    = 8'hD8,
  parameter int              MAX_BITS = 64,
  parameter int              CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  crc_serial_gen_if.slave   bus,
  output logic [1:0]        dbg_state,
  output logic [CRC_W-1:0]  dbg_lfsr
);

  localparam int SH_W = $clog2(CRC_W + 1);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [SH_W-1:0]  SH_LAST = SH_W'(CRC_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   lfsr_q,  lfsr_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [SH_W-1:0]    shcnt_q, shcnt_d;
  logic               crc_q,   crc_d;
  logic               valid_q, valid_d;
  logic               done_q,  done_d;
  logic               ovf_q,   ovf_d;
  logic               ready_q, ready_d;
`ifdef CRC_SERIAL_CHECK_EN
  logic               chk_q,   chk_d;
`endif

  // One Galois-style LFSR step. The feedback enters at the MSB, and every
  // lower bit takes its upper neighbour, XORed with the feedback where the
  // tap mask is set. The tap at the MSB is ignored because that bit is
  // always the feedback itself.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] cur,
                                                 input logic             din);
    logic             fb;
    logic [CRC_W-1:0] nxt;
    fb  = cur[0] ^ din;
    nxt = (cur >> 1) ^ (TAPS & {CRC_W{fb}});
    nxt[CRC_W-1] = fb;
    return nxt;
  endfunction

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    bitcnt_d = bitcnt_q;
    shcnt_d  = shcnt_q;
    crc_d    = crc_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
`ifdef CRC_SERIAL_CHECK_EN
    chk_d    = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        // LFSR already holds SEED here: from reset or from the end of SHIFT.
        if (bus.ACTIVE) begin
          lfsr_d   = lfsr_step(lfsr_q, bus.DATA);
          bitcnt_d = CNT_W'(1);
          ovf_d    = 1'b0;
`ifdef CRC_SERIAL_CHECK_EN
          chk_d    = 1'b0;
`endif
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        if (bus.ACTIVE && (bitcnt_q < MAX_CNT)) begin
          lfsr_d   = lfsr_step(lfsr_q, bus.DATA);
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end else begin
          // Frame over, either because ACTIVE dropped or because the length
          // limit was hit. On a limit hit the offered bit is not absorbed.
          // The first CRC bit leaves on this same edge, so VALID follows the
          // first ACTIVE-low sample by exactly one edge.
          if (bus.ACTIVE) begin
            ovf_d = 1'b1;
          end
`ifdef CRC_SERIAL_CHECK_EN
          chk_d    = (lfsr_q == '0);
`endif
          crc_d    = lfsr_q[0];
          lfsr_d   = lfsr_q >> 1;
          valid_d  = 1'b1;
          shcnt_d  = SH_W'(1);
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // DATA/ACTIVE are not looked at here. READY is low, so the source
        // knows these cycles are not accepted.
        if (shcnt_q < SH_LAST) begin
          crc_d   = lfsr_q[0];
          lfsr_d  = lfsr_q >> 1;
          shcnt_d = shcnt_q + SH_W'(1);
        end else begin
          // The LFSR has been shifted empty. Reload the seed now, so that a
          // frame starting in the DONE cycle begins from SEED.
          crc_d   = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b1;
          lfsr_d  = SEED;
          shcnt_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        lfsr_d  = SEED;
      end
    endcase

    ready_d = (state_d != S_SHIFT);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      bitcnt_q <= '0;
      shcnt_q  <= '0;
      crc_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
`ifdef CRC_SERIAL_CHECK_EN
      chk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      bitcnt_q <= bitcnt_d;
      shcnt_q  <= shcnt_d;
      crc_q    <= crc_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
`ifdef CRC_SERIAL_CHECK_EN
      chk_q    <= chk_d;
`endif
    end
  end

  assign bus.CRC   = crc_q;
  assign bus.VALID = valid_q;
  assign bus.DONE  = done_q;
  assign bus.OVF   = ovf_q;
  assign bus.READY = ready_q;
`ifdef CRC_SERIAL_CHECK_EN
  assign bus.CHK_OK = chk_q;
`endif

  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr_q;

endmodule

// File: tb/tb_crc_serial_gen.sv
// -----------------------------------------------------------------------------
// tb_crc_serial_gen
//
// Directed bench for crc_serial_gen. The DUT uses CRC_W=8, TAPS=8'h44,
// SEED=8'hD8 and MAX_BITS=4, so that the length limit is easy to reach.
// Expected LFSR values are worked by hand from SEED:
//   DATA=0               -> 8'h6C
//   DATA=1               -> 8'hA8
//   1,0,1                -> 8'hEE
//   1,0,1,1              -> 8'hB3
// With CRC_SERIAL_CHECK_EN, a second instance (MAX_BITS=16) checks the
// receive-side residue on 9-bit frames.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_crc_serial_gen;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  crc_serial_gen_if bus();
  logic [1:0] dbg_state;
  logic [7:0] dbg_lfsr;

  crc_serial_gen #(
    .CRC_W(8), .TAPS(8'h44), .SEED(8'hD8), .MAX_BITS(4), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

`ifdef CRC_SERIAL_CHECK_EN
  crc_serial_gen_if bus_c();
  logic [1:0] c_state;
  logic [7:0] c_lfsr;

  crc_serial_gen #(
    .CRC_W(8), .TAPS(8'h44), .SEED(8'hD8), .MAX_BITS(16), .CNT_W(16)
  ) dut_c (
    .CLK(CLK), .RST(RST), .bus(bus_c), .dbg_state(c_state), .dbg_lfsr(c_lfsr)
  );
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the 8 CRC bits of a final LFSR value, in transmit order (LSB first).
  task automatic push_exp(input logic [7:0] v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
  endtask

  // Call at a falling edge. Presents n bits, LSB of 'bits' first. Returns at
  // the falling edge after the last bit, with ACTIVE driven low.
  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk("ready_in", bus.READY, 1);
      bus.ACTIVE = 1'b1;
      bus.DATA   = bits[i];
      @(negedge CLK);
    end
    bus.ACTIVE = 1'b0;
    bus.DATA   = 1'b0;
  endtask

  // Checks nbits VALID cycles against exp_q, then the DONE cycle. Returns at
  // the falling edge where DONE is high.
  task automatic collect(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      chk("valid", bus.VALID, 1);
      chk("crc_bit", bus.CRC, exp_q.pop_front());
      chk("ready_shift", bus.READY, 0);
      chk("done_early", bus.DONE, 0);
    end
    @(negedge CLK);
    chk("valid_end", bus.VALID, 0);
    chk("done", bus.DONE, 1);
    chk("ready_end", bus.READY, 1);
  endtask

`ifdef CRC_SERIAL_CHECK_EN
  task automatic send_c(input logic [31:0] bits, input int n, input logic exp_ok);
    for (int i = 0; i < n; i++) begin
      bus_c.ACTIVE = 1'b1;
      bus_c.DATA   = bits[i];
      @(negedge CLK);
    end
    bus_c.ACTIVE = 1'b0;
    bus_c.DATA   = 1'b0;
    @(negedge CLK);
    chk("chk_valid", bus_c.VALID, 1);
    chk("chk_ok", bus_c.CHK_OK, exp_ok);
    repeat (8) @(negedge CLK);
    chk("chk_done", bus_c.DONE, 1);
  endtask
`endif

  initial begin
    logic [3:0] ob;
    bus.DATA   = 1'b0;
    bus.ACTIVE = 1'b0;
`ifdef CRC_SERIAL_CHECK_EN
    bus_c.DATA   = 1'b0;
    bus_c.ACTIVE = 1'b0;
`endif
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset values
    chk("rst_crc", bus.CRC, 0);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_ovf", bus.OVF, 0);
    chk("rst_ready", bus.READY, 1);
    chk("rst_state", dbg_state, 0);
`ifdef CRC_SERIAL_CHECK_EN
    chk("rst_chk_ok", bus_c.CHK_OK, 0);
    chk("rst_c_state", c_state, 0);
`endif
    RST = 1'b1;
    @(negedge CLK);
    chk("seed", dbg_lfsr, 8'hD8);

    // Single bit 0 -> 6C
    push_exp(8'h6C);
    send_bits(32'h0, 1);
    chk("lfsr_0", dbg_lfsr, 8'h6C);
    collect(8);
    @(negedge CLK);
    chk("done_pulse", bus.DONE, 0);

    // Single bit 1 -> A8, then an identical frame started in the DONE cycle
    push_exp(8'hA8);
    send_bits(32'h1, 1);
    chk("lfsr_1", dbg_lfsr, 8'hA8);
    collect(8);
    push_exp(8'hA8);
    send_bits(32'h1, 1);
    chk("lfsr_b2b", dbg_lfsr, 8'hA8);
    collect(8);
    @(negedge CLK);

    // 3-bit frame 1,0,1 -> EE
    push_exp(8'hEE);
    send_bits(32'h5, 3);
    chk("lfsr_3b", dbg_lfsr, 8'hEE);
    collect(8);
    chk("ovf_3b", bus.OVF, 0);
    @(negedge CLK);

    // Exactly MAX_BITS=4 bits, 1,0,1,1 -> B3, no overflow
    push_exp(8'hB3);
    send_bits(32'hD, 4);
    chk("lfsr_4b", dbg_lfsr, 8'hB3);
    collect(8);
    chk("ovf_4b", bus.OVF, 0);
    @(negedge CLK);

    // Overflow: ACTIVE held for 6 cycles, so only the first 4 bits count
    push_exp(8'hB3);
    ob = 4'hD;
    for (int i = 0; i < 4; i++) begin
      bus.ACTIVE = 1'b1;
      bus.DATA   = ob[i];
      @(negedge CLK);
    end
    bus.ACTIVE = 1'b1;
    bus.DATA   = 1'b0;
    chk("lfsr_ovf", dbg_lfsr, 8'hB3);
    chk("ovf_pre", bus.OVF, 0);
    @(negedge CLK);
    chk("ovf_set", bus.OVF, 1);
    chk("ovf_valid0", bus.VALID, 1);
    chk("ovf_crc0", bus.CRC, exp_q.pop_front());
    chk("ovf_ready", bus.READY, 0);
    bus.DATA = 1'b1;
    @(negedge CLK);
    chk("ovf_valid1", bus.VALID, 1);
    chk("ovf_crc1", bus.CRC, exp_q.pop_front());
    bus.ACTIVE = 1'b0;
    bus.DATA   = 1'b0;
    collect(6);
    chk("ovf_sticky_done", bus.OVF, 1);
    @(negedge CLK);
    chk("ovf_sticky_idle", bus.OVF, 1);
    push_exp(8'h6C);
    send_bits(32'h0, 1);
    chk("ovf_cleared", bus.OVF, 0);
    collect(8);
    @(negedge CLK);

    // Reset in the middle of the shift-out
    push_exp(8'h6C);
    send_bits(32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_valid", bus.VALID, 1);
      chk("mid_crc", bus.CRC, exp_q.pop_front());
    end
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", bus.VALID, 0);
    chk("mid_rst_done", bus.DONE, 0);
    chk("mid_rst_ready", bus.READY, 1);
    chk("mid_rst_lfsr", dbg_lfsr, 8'hD8);
    exp_q.delete();
    repeat (2) begin
      @(negedge CLK);
      chk("mid_no_done", bus.DONE, 0);
    end
    RST = 1'b1;
    @(negedge CLK);
    push_exp(8'h6C);
    send_bits(32'h0, 1);
    chk("lfsr_after_rst", dbg_lfsr, 8'h6C);
    collect(8);
    @(negedge CLK);

`ifdef CRC_SERIAL_CHECK_EN
    // Data 0 followed by its own CRC 0,0,1,1,0,1,1,0 leaves a zero residue
    send_c(32'h0D8, 9, 1'b1);
    send_c(32'h0D9, 9, 1'b0);
    send_c(32'h1D8, 9, 1'b0);
    @(negedge CLK);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
